// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS controller: sequences FETCH..WRITEBACK per instruction, stalls on mem_ready,
// traps unsupported opcodes and hung memory accesses, and counts retired instructions.
module multicycle_control_fsm #(
    parameter int WAIT_LIMIT = 255,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       func,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             branch_ne,
    output logic [1:0]       pc_source,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             illegal_op,
    output logic             bus_err,
    output logic [CNT_W-1:0] instr_count,
    output logic [3:0]       o_dbg_state
);

    localparam int WAIT_W = $clog2(WAIT_LIMIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_LIMIT - 1);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_R_EXEC   = 4'd3,
        S_R_WB     = 4'd4,
        S_I_EXEC   = 4'd5,
        S_I_WB     = 4'd6,
        S_MEM_ADDR = 4'd7,
        S_MEM_RD   = 4'd8,
        S_MEM_WB   = 4'd9,
        S_MEM_WR   = 4'd10,
        S_BRANCH   = 4'd11,
        S_JUMP     = 4'd12,
        S_TRAP     = 4'd13
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [WAIT_W-1:0]  r_wait;
    logic [CNT_W-1:0]   r_count;
    logic               r_is_sw;
    logic               r_is_bne;
    logic               r_trap_bus;
    logic               w_timeout;
    logic               w_func_ok;
    logic               w_mem_state;
    logic               w_retire;

    assign w_timeout   = !mem_ready && (r_wait == WAIT_LAST);
    assign w_func_ok   = func inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02};
    assign w_mem_state = r_state inside {S_FETCH, S_MEM_RD, S_MEM_WR};
    assign w_retire    = (w_next == S_FETCH) &&
                         (r_state inside {S_R_WB, S_I_WB, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_IDLE:   w_next = S_FETCH;
            S_FETCH:  w_next = mem_ready ? S_DECODE : (w_timeout ? S_TRAP : S_FETCH);
            S_DECODE: begin
                case (opcode)
                    6'h00:               w_next = w_func_ok ? S_R_EXEC : S_TRAP;
                    6'h23, 6'h2B:        w_next = S_MEM_ADDR;
                    6'h04, 6'h05:        w_next = S_BRANCH;
                    6'h02:               w_next = S_JUMP;
                    6'h08, 6'h0C, 6'h0D,
                    6'h0A:               w_next = S_I_EXEC;
                    default:             w_next = S_TRAP;
                endcase
            end
            S_R_EXEC:   w_next = S_R_WB;
            S_R_WB:     w_next = S_FETCH;
            S_I_EXEC:   w_next = S_I_WB;
            S_I_WB:     w_next = S_FETCH;
            S_MEM_ADDR: w_next = r_is_sw ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   w_next = mem_ready ? S_MEM_WB : (w_timeout ? S_TRAP : S_MEM_RD);
            S_MEM_WB:   w_next = S_FETCH;
            S_MEM_WR:   w_next = mem_ready ? S_FETCH : (w_timeout ? S_TRAP : S_MEM_WR);
            S_BRANCH:   w_next = S_FETCH;
            S_JUMP:     w_next = S_FETCH;
            S_TRAP:     w_next = S_FETCH;
            default:    w_next = S_IDLE;
        endcase
    end

    // Wait counter restarts whenever a memory state is entered; it only counts while stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait     <= '0;
            r_count    <= '0;
            r_is_sw    <= 1'b0;
            r_is_bne   <= 1'b0;
            r_trap_bus <= 1'b0;
        end else begin
            if ((w_next == r_state) && w_mem_state) begin
                r_wait <= r_wait + WAIT_W'(1);
            end else begin
                r_wait <= '0;
            end
            if (w_retire) begin
                r_count <= r_count + CNT_W'(1);
            end
            if (r_state == S_DECODE) begin
                r_is_sw  <= (opcode == 6'h2B);
                r_is_bne <= (opcode == 6'h05);
            end
            if (w_next == S_TRAP) begin
                r_trap_bus <= (r_state != S_DECODE);
            end
        end
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_ne     = 1'b0;
        pc_source     = 2'd0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'd0;
        alu_op        = 2'd0;
        illegal_op    = 1'b0;
        bus_err       = 1'b0;
        case (r_state)
            S_FETCH: begin
                // PC and IR only load in the cycle the fetch actually completes.
                mem_read  = 1'b1;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                alu_src_b = 2'd1;
            end
            S_DECODE: alu_src_b = 2'd3;
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_R_WB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            S_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                alu_op    = 2'b11;
            end
            S_I_WB: reg_write = 1'b1;
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_source     = 2'd1;
                pc_write_cond = !r_is_bne;
                branch_ne     = r_is_bne;
            end
            S_JUMP: begin
                pc_source = 2'd2;
                pc_write  = 1'b1;
            end
            S_TRAP: begin
                pc_source  = 2'd3;
                pc_write   = 1'b1;
                illegal_op = !r_trap_bus;
                bus_err    = r_trap_bus;
            end
            default: ;
        endcase
    end

    assign instr_count = r_count;
    assign o_dbg_state = r_state;

endmodule
